burst_rr_sched: RTL

BURST_RR_SCHED -- requirements
Module: burst_rr_sched

---
 rtl/burst_rr_sched_pkg.sv | 20 ++
 rtl/burst_rr_sched_rr_pick.sv | 30 +++
 rtl/burst_rr_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/burst_rr_sched_pkg.sv
// Shared types for the burst round-robin scheduler.
// Holds the FSM state enum, the weight type and the zero-weight helper.
package burst_rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        REL  = 2'd2
    } state_t;

    // Weight container; WW must not exceed WW_MAX.
    localparam int WW_MAX = 16;
    typedef logic [WW_MAX-1:0] weight_t;

    // A quantum of 0 still grants one full packet.
    function automatic weight_t eff_weight(input weight_t w);
        return (w == '0) ? weight_t'(1) : w;
    endfunction

endpackage

// File: rtl/burst_rr_sched_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; onehot, idx out (zero when req is zero).
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        j      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/burst_rr_sched.sv
// Packet-granular weighted round-robin scheduler for a shared resource.
// Ports: req/last/weight per requester, res_ready in; grant, grant_id, beat_fire out.
module burst_rr_sched
    import burst_rr_sched_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic [N*WW-1:0] weight,
    input  logic            res_ready,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_id,
    output logic            beat_fire
);

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [N-1:0]  grant_nx;
    logic [IW-1:0] gid_nx;
    logic [WW-1:0] wlat, wlat_nx;
    logic [WW-1:0] cnt, cnt_nx, cnt_inc;
    logic          mid, mid_nx;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    weight_t       wfield, weff;
    logic          fire_last;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign wfield    = weight_t'(weight[int'(pick_idx)*WW +: WW]);
    assign weff      = eff_weight(wfield);
    assign beat_fire = (|(grant & req)) & res_ready;
    assign fire_last = beat_fire & last[owner];
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        grant_nx = grant;
        gid_nx   = grant_id;
        wlat_nx  = wlat;
        cnt_nx   = cnt;
        mid_nx   = mid;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = OWN;
                    owner_nx = pick_idx;
                    grant_nx = pick_oh;
                    gid_nx   = pick_idx;
                    wlat_nx  = weff[WW-1:0];
                    cnt_nx   = '0;
                    mid_nx   = 1'b0;
                end
            end
            OWN: begin
                if (fire_last) begin
                    cnt_nx = cnt_inc;
                    mid_nx = 1'b0;
                    if (cnt_inc == wlat) begin
                        state_nx = REL;
                        grant_nx = '0;
                        gid_nx   = '0;
                    end
                end else if (beat_fire) begin
                    mid_nx = 1'b1;
                end else if (!req[owner] && cnt != '0 && !mid) begin
                    // Owner went quiet on a packet boundary.
                    state_nx = REL;
                    grant_nx = '0;
                    gid_nx   = '0;
                end
            end
            REL: begin
                state_nx = IDLE;
                ptr_nx   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                cnt_nx   = '0;
                mid_nx   = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                gid_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            grant_id <= '0;
            wlat     <= '0;
            cnt      <= '0;
            mid      <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            grant    <= grant_nx;
            grant_id <= gid_nx;
            wlat     <= wlat_nx;
            cnt      <= cnt_nx;
            mid      <= mid_nx;
        end
    end

endmodule
